// File: rtl/kara142_seq.sv
// kara142_seq: iterative 142x142 GF(2) Karatsuba sequencer over one shared 71-bit multiplier.
// Optional KARA142_ZERO_SKIP_EN: a zero operand bypasses the three multiplier requests.
module kara142_seq #(
  parameter int N = 142,
  parameter int H = 71
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*N-2:0]   result,
  output logic             mul_req,
  output logic [H-1:0]     mul_a,
  output logic [H-1:0]     mul_b,
  input  logic             mul_ack,
  input  logic [2*H-2:0]   mul_p
);
  localparam int W = 2*N-1;
  localparam int P = 2*H-1;
  typedef enum logic [2:0] {IDLE, ISS_L, ISS_H, ISS_M, COMBINE, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [P-1:0] pl_q, pl_d, ph_q, ph_d, pm_q, pm_d, mid;
  logic [W-1:0] result_q, result_d;
  logic mul_req_q, mul_req_d;
  logic [H-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    pl_d     = pl_q;
    ph_d     = ph_q;
    pm_d     = pm_q;
    result_d = result_q;
    mid      = pm_q ^ pl_q ^ ph_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        state_d = ISS_L;
`ifdef KARA142_ZERO_SKIP_EN
        if (a == '0 || b == '0) begin
          state_d = COMBINE;
          pl_d    = '0;
          ph_d    = '0;
          pm_d    = '0;
        end
`endif
      end
      ISS_L: if (mul_ack) begin
        pl_d    = mul_p;
        state_d = ISS_H;
      end
      ISS_H: if (mul_ack) begin
        ph_d    = mul_p;
        state_d = ISS_M;
      end
      ISS_M: if (mul_ack) begin
        pm_d    = mul_p;
        state_d = COMBINE;
      end
      COMBINE: begin
        result_d = W'(pl_q) ^ (W'(mid) << H) ^ (W'(ph_q) << N);
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Operands are registered alongside the state so they are valid on entry to each issue state
    mul_req_d = state_d == ISS_L || state_d == ISS_H || state_d == ISS_M;
    mul_a_d   = state_d == ISS_L ? a_d[H-1:0] : state_d == ISS_H ? a_d[N-1:H] :
                state_d == ISS_M ? a_d[H-1:0] ^ a_d[N-1:H] : '0;
    mul_b_d   = state_d == ISS_L ? b_d[H-1:0] : state_d == ISS_H ? b_d[N-1:H] :
                state_d == ISS_M ? b_d[H-1:0] ^ b_d[N-1:H] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      pl_q      <= '0;
      ph_q      <= '0;
      pm_q      <= '0;
      result_q  <= '0;
      mul_req_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      pl_q      <= pl_d;
      ph_q      <= ph_d;
      pm_q      <= pm_d;
      result_q  <= result_d;
      mul_req_q <= mul_req_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign result  = result_q;
  assign mul_req = mul_req_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
endmodule
